// File: rtl/spi_divmmc_arb_if.sv
// spi_divmmc_arb_if -- bus bundle between the two requesters, the arbiter
// and the byte-level DivMMC SPI engine.
//
// Requester side : req0/1, wr0/1, din0/1, lock0/1, cs0/1 (to arbiter)
//                  ack0/1, dout (from arbiter)
// Engine side    : eng_ready, eng_dout (to arbiter)
//                  eng_tx, eng_rx, eng_din (from arbiter)
// Status         : spi_cs_n, owner, busy (from arbiter)
//
// slave  : the arbiter's view.
// master : the view of whatever surrounds it (requesters + engine).
interface spi_divmmc_arb_if;
    logic       req0, req1;
    logic       wr0, wr1;
    logic [7:0] din0, din1;
    logic       lock0, lock1;
    logic       cs0, cs1;
    logic       ack0, ack1;
    logic [7:0] dout;
    logic       eng_ready;
    logic       eng_tx, eng_rx;
    logic [7:0] eng_din;
    logic [7:0] eng_dout;
    logic       spi_cs_n;
    logic       owner;
    logic       busy;

    modport slave (
        input  req0, req1, wr0, wr1, din0, din1, lock0, lock1, cs0, cs1,
        input  eng_ready, eng_dout,
        output ack0, ack1, dout, eng_tx, eng_rx, eng_din,
        output spi_cs_n, owner, busy
    );

    modport master (
        output req0, req1, wr0, wr1, din0, din1, lock0, lock1, cs0, cs1,
        output eng_ready, eng_dout,
        input  ack0, ack1, dout, eng_tx, eng_rx, eng_din,
        input  spi_cs_n, owner, busy
    );
endinterface

// File: rtl/spi_divmmc_arb.sv
// spi_divmmc_arb -- two-requester arbiter/sequencer in front of the DivMMC
// byte SPI engine. Requester 0 is the CPU I/O port, requester 1 the boot
// loader. One byte transfer at a time: grant, strobe the engine, capture the
// read-ahead byte, wait for the engine, ack the owner.
//
// Ports:
//   clk_sys  : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : spi_divmmc_arb_if.slave (requests/acks, engine strobes,
//              card select, owner and busy status)
//
// Parameters:
//   TIMEOUT_W : width of the lock watchdog counter (only with
//               SPI_ARB_TIMEOUT_EN defined).
//
// Build option:
//   SPI_ARB_TIMEOUT_EN : when defined, a lock held in IDLE with no request
//                        from its owner is force-released once the watchdog
//                        counter reaches all-ones.
module spi_divmmc_arb #(
    parameter int TIMEOUT_W = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    spi_divmmc_arb_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, LATCH, WAIT, ACK} state_t;

    state_t     state, state_nx;
    logic       owner_q, owner_nx;
    logic       lock_q, lock_nx;
    logic [7:0] shadow;   // engine byte captured the cycle after the strobe
    logic [7:0] dout_q;   // last acked byte, held between acks

    logic       own_req, own_wr, own_lock, own_cs;
    logic [7:0] own_din;
    logic       gnt, gnt_id;
    logic       tmo;

    logic       ack0, ack1, eng_tx, eng_rx;
    logic [7:0] eng_din;
    logic       busy;

    // Owner's view of the request bundle.
    always_comb begin
        own_req  = owner_q ? bus.req1  : bus.req0;
        own_wr   = owner_q ? bus.wr1   : bus.wr0;
        own_lock = owner_q ? bus.lock1 : bus.lock0;
        own_cs   = owner_q ? bus.cs1   : bus.cs0;
        own_din  = owner_q ? bus.din1  : bus.din0;
    end

    // Grant decision: a held lock restricts to the owner; a tie goes to the
    // requester that did not have the engine last.
    always_comb begin
        gnt    = 1'b0;
        gnt_id = owner_q;
        if (lock_q) begin
            gnt    = own_req;
            gnt_id = owner_q;
        end else if (bus.req0 && bus.req1) begin
            gnt    = 1'b1;
            gnt_id = ~owner_q;
        end else if (bus.req0) begin
            gnt    = 1'b1;
            gnt_id = 1'b0;
        end else if (bus.req1) begin
            gnt    = 1'b1;
            gnt_id = 1'b1;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog on an idle lock; any grant leaves IDLE or sees own_req and
    // clears it.
    logic [TIMEOUT_W-1:0] tcnt;
    logic                 idle_lock;

    assign idle_lock = (state == IDLE) && lock_q && !own_req;
    assign tmo       = idle_lock && (&tcnt);

    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            tcnt <= '0;
        else if (idle_lock && !tmo)
            tcnt <= tcnt + 1'b1;
        else
            tcnt <= '0;
    end
`else
    assign tmo = 1'b0;
`endif

    // Next state and strobes.
    always_comb begin
        state_nx = state;
        owner_nx = owner_q;
        lock_nx  = lock_q;
        ack0     = 1'b0;
        ack1     = 1'b0;
        eng_tx   = 1'b0;
        eng_rx   = 1'b0;
        eng_din  = 8'h00;
        unique case (state)
            IDLE: begin
                if ((lock_q && !own_lock) || tmo)
                    lock_nx = 1'b0;
                if (gnt) begin
                    owner_nx = gnt_id;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.eng_ready) begin
                    eng_tx   = own_wr;
                    eng_rx   = ~own_wr;
                    eng_din  = own_din;
                    state_nx = LATCH;
                end
            end
            LATCH: state_nx = WAIT;
            WAIT: begin
                if (bus.eng_ready)
                    state_nx = ACK;
            end
            ACK: begin
                ack0     = ~owner_q;
                ack1     = owner_q;
                lock_nx  = own_lock;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner_q <= 1'b1;
            lock_q  <= 1'b0;
            shadow  <= 8'h00;
            dout_q  <= 8'h00;
        end else begin
            state   <= state_nx;
            owner_q <= owner_nx;
            lock_q  <= lock_nx;
            // Engine latches its output at start, so this is the byte the
            // previous transfer received.
            if (state == LATCH)
                shadow <= bus.eng_dout;
            if (state == ACK)
                dout_q <= shadow;
        end
    end

    assign busy         = (state != IDLE) || lock_q;
    assign bus.busy     = busy;
    assign bus.spi_cs_n = busy ? ~own_cs : 1'b1;
    assign bus.owner    = owner_q;
    assign bus.ack0     = ack0;
    assign bus.ack1     = ack1;
    assign bus.eng_tx   = eng_tx;
    assign bus.eng_rx   = eng_rx;
    assign bus.eng_din  = eng_din;
    // dout is valid in the ack cycle itself, then held.
    assign bus.dout     = (state == ACK) ? shadow : dout_q;

endmodule
